// File: rtl/ild1420_avg.sv
// Boxcar moving average over the last 2^LOG2_N error-free ILD1420 samples,
// with saturating reject counter, stale-stream detection and window flush.
module ild1420_avg #(
  parameter int LOG2_N       = 3,
  parameter int STALE_CYCLES = 60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_distance,
  input  logic [1:0]  in_error,
  input  logic        clear,
  output logic [15:0] out_distance,
  output logic        out_valid,
  output logic        primed,
  output logic        stale,
  output logic [15:0] reject_count
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = 16 + LOG2_N;
  localparam int FW = LOG2_N + 1;
  localparam int TW = $clog2(STALE_CYCLES + 1);

  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [SW-1:0]       sum_r, sum_s;
  logic [FW-1:0]       fill_r, fill_s;
  logic [LOG2_N-1:0]   wr_ptr_r, wr_ptr_s;
  logic [TW-1:0]       timer_r, timer_s;
  logic [15:0]         win_r [N];
  logic [15:0]         oldest_s;
  logic                upd_r, upd_s;
  logic                primed_s, stale_s;
  logic                accept_s, reject_s, expire_s, flush_s, write_s;

  // Input qualification and stale timer; accept beats a same-cycle expiry.
  always_comb begin
    accept_s = in_valid && (in_error == 2'b00) && !clear;
    reject_s = in_valid && (in_error != 2'b00) && !clear;
    oldest_s = win_r[wr_ptr_r];
    if (accept_s || clear) begin
      timer_s = '0;
    end else if (timer_r == TW'(STALE_CYCLES)) begin
      timer_s = timer_r;
    end else begin
      timer_s = timer_r + TW'(1);
    end
    expire_s = !accept_s && !clear && (timer_s == TW'(STALE_CYCLES));
    flush_s  = clear || expire_s;
  end

  // Window FSM next state: fill phase, then running sum with oldest removal.
  always_comb begin
    state_s  = state_r;
    sum_s    = sum_r;
    fill_s   = fill_r;
    wr_ptr_s = wr_ptr_r;
    primed_s = primed;
    upd_s    = 1'b0;
    write_s  = 1'b0;
    if (flush_s) begin
      state_s  = FILL;
      sum_s    = '0;
      fill_s   = '0;
      wr_ptr_s = '0;
      primed_s = 1'b0;
    end else if (accept_s) begin
      write_s  = 1'b1;
      wr_ptr_s = wr_ptr_r + LOG2_N'(1);
      case (state_r)
        FILL: begin
          sum_s  = sum_r + SW'(in_distance);
          fill_s = fill_r + FW'(1);
          if (fill_r == FW'(N - 1)) begin
            state_s  = RUN;
            primed_s = 1'b1;
            upd_s    = 1'b1;
          end else begin
            state_s  = FILL;
          end
        end
        RUN: begin
          sum_s = sum_r + SW'(in_distance) - SW'(oldest_s);
          upd_s = 1'b1;
        end
        default: begin
          state_s = FILL;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    if (clear || accept_s) begin
      stale_s = 1'b0;
    end else if (expire_s) begin
      stale_s = 1'b1;
    end else begin
      stale_s = stale;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FILL;
      sum_r        <= '0;
      fill_r       <= '0;
      wr_ptr_r     <= '0;
      timer_r      <= '0;
      upd_r        <= 1'b0;
      primed       <= 1'b0;
      stale        <= 1'b0;
      reject_count <= 16'h0000;
    end else begin
      state_r  <= state_s;
      sum_r    <= sum_s;
      fill_r   <= fill_s;
      wr_ptr_r <= wr_ptr_s;
      timer_r  <= timer_s;
      upd_r    <= upd_s;
      primed   <= primed_s;
      stale    <= stale_s;
      if (reject_s && (reject_count != 16'hFFFF)) begin
        reject_count <= reject_count + 16'h0001;
      end
    end
  end

  // Sample storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (write_s) begin
      win_r[wr_ptr_r] <= in_distance;
    end
  end

  // Output stage reads the pre-flush sum, so a pending pulse survives a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_distance <= 16'h0000;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= upd_r;
      if (upd_r) begin
        out_distance <= sum_r[SW-1:LOG2_N];
      end
    end
  end

endmodule

// File: tb/tb_ild1420_avg.sv
// Scoreboard bench for ild1420_avg: queue-based reference window, directed
// scenarios followed by randomized traffic with resets, clears and idle gaps.
module tb_ild1420_avg;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int STALE  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_distance;
  logic [1:0]  in_error;
  logic        clear;
  logic [15:0] out_distance;
  logic        out_valid;
  logic        primed;
  logic        stale;
  logic [15:0] reject_count;

  ild1420_avg #(.LOG2_N(LOG2_N), .STALE_CYCLES(STALE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_distance(in_distance),
    .in_error(in_error), .clear(clear), .out_distance(out_distance),
    .out_valid(out_valid), .primed(primed), .stale(stale),
    .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  typedef struct { int v; int e; } exp_t;
  exp_t exp_q[$];
  int   win_q[$];
  int   edge_n = 0;
  int   m_timer = 0;
  int   m_rej = 0;
  int   m_out = 0;
  bit   m_stale = 1'b0;
  bit   m_primed = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  // Reference model: window as a queue, average as plain arithmetic.
  always @(posedge clk) begin
    bit acc;
    bit rej;
    int s;
    edge_n++;
    if (rst) begin
      win_q.delete(); exp_q.delete();
      m_timer = 0; m_rej = 0; m_out = 0; m_stale = 0; m_primed = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].e == edge_n) m_out = exp_q[0].v;
      acc = in_valid && in_error == 2'b00 && !clear;
      rej = in_valid && in_error != 2'b00 && !clear;
      if (rej && m_rej < 65535) m_rej++;
      if (acc) begin
        win_q.push_back(int'(in_distance));
        if (win_q.size() > N) void'(win_q.pop_front());
        m_timer = 0; m_stale = 0;
        if (win_q.size() == N) begin
          m_primed = 1;
          s = 0;
          foreach (win_q[i]) s += win_q[i];
          exp_q.push_back('{v: s / N, e: edge_n + 1});
        end
      end else if (clear) begin
        win_q.delete(); m_timer = 0; m_stale = 0; m_primed = 0;
      end else begin
        if (m_timer < STALE) m_timer++;
        if (m_timer == STALE) begin
          m_stale = 1; m_primed = 0; win_q.delete();
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every out_valid and checks status outputs.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_distance", int'(out_distance), e.v);
        chk("out_latency_edge", edge_n, e.e);
      end
    end else if (exp_q.size() > 0 && exp_q[0].e <= edge_n) begin
      e = exp_q.pop_front();
      chk("missing_out_valid", 0, 1);
    end
    chk("out_distance_hold", int'(out_distance), m_out);
    chk("primed", int'(primed), int'(m_primed));
    chk("stale", int'(stale), int'(m_stale));
    chk("reject_count", int'(reject_count), m_rej);
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic [1:0] e, input logic c);
    in_valid = v; in_distance = d; in_error = e; clear = c;
    @(negedge clk);
    in_valid = 1'b0; in_distance = 16'h0000; in_error = 2'b00; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'h0000, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_distance = 16'h0000; in_error = 2'b00; clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_distance", int'(out_distance), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_reject_count", int'(reject_count), 0);
    rst = 1'b0;

    cyc(1'b1, 16'd100, 2'b00, 1'b0);
    cyc(1'b1, 16'd200, 2'b00, 1'b0);
    cyc(1'b1, 16'd300, 2'b00, 1'b0);
    cyc(1'b1, 16'd400, 2'b00, 1'b0);
    chk("fill_no_early_valid", int'(out_valid), 0);
    idle(1);
    chk("first_avg_valid", int'(out_valid), 1);
    chk("first_avg", int'(out_distance), 250);
    chk("first_primed", int'(primed), 1);
    cyc(1'b1, 16'd500, 2'b00, 1'b0); idle(1);
    chk("avg_350", int'(out_distance), 350);
    cyc(1'b1, 16'h0001, 2'b00, 1'b0); idle(1);
    chk("avg_300", int'(out_distance), 300);
    cyc(1'b1, 16'd9999, 2'b01, 1'b0);
    chk("reject_one", int'(reject_count), 1);
    chk("reject_no_valid", int'(out_valid), 0);
    cyc(1'b1, 16'd5, 2'b00, 1'b0); idle(1);
    chk("avg_excl_reject", int'(out_distance), 226);

    idle(50);
    chk("not_stale_yet", int'(stale), 0);
    idle(70);
    chk("stale_set", int'(stale), 1);
    chk("stale_unprimed", int'(primed), 0);
    chk("stale_hold_out", int'(out_distance), 226);
    cyc(1'b1, 16'd8, 2'b00, 1'b0);
    chk("stale_cleared", int'(stale), 0);
    cyc(1'b1, 16'd8, 2'b00, 1'b0);
    cyc(1'b1, 16'd8, 2'b00, 1'b0);
    cyc(1'b1, 16'd12, 2'b00, 1'b0); idle(1);
    chk("reprime_avg", int'(out_distance), 9);

    repeat (N) cyc(1'b1, 16'hFFFF, 2'b00, 1'b0);
    idle(1);
    chk("max_avg", int'(out_distance), 65535);
    cyc(1'b1, 16'd123, 2'b00, 1'b1);
    chk("clear_unprimed", int'(primed), 0);
    chk("clear_no_reject", int'(reject_count), 1);

    for (int i = 0; i < 70000; i++) cyc(1'b1, 16'($urandom), 2'($urandom_range(1, 3)), 1'b0);
    chk("reject_saturate", int'(reject_count), 65535);

    cyc(1'b1, 16'd1, 2'b00, 1'b0);
    cyc(1'b1, 16'd2, 2'b00, 1'b0);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("midrst_out", int'(out_distance), 0);
    chk("midrst_rej", int'(reject_count), 0);
    chk("midrst_primed", int'(primed), 0);
    cyc(1'b1, 16'd10, 2'b00, 1'b0);
    cyc(1'b1, 16'd20, 2'b00, 1'b0);
    cyc(1'b1, 16'd30, 2'b00, 1'b0);
    cyc(1'b1, 16'd40, 2'b00, 1'b0); idle(1);
    chk("post_rst_avg", int'(out_distance), 25);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 4) begin
        rst = 1'b1; idle(1); rst = 1'b0;
      end else if (r < 9) begin
        idle(STALE + 5);
      end else if (r < 30) begin
        cyc(1'b1, 16'($urandom), 2'b00, 1'b1);
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), 16'($urandom),
            ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b0);
      end
    end
    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
